spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
SPI target (slave) endpoint, the receiving end of the SPI link whose SCLK comes from the clock divider. It oversamples external SCLK, CS_n and MOSI in the sys_clk_in domain. It deserialises MOSI into parallel words and serialises local data onto MISO. The local side uses a valid/ready TX holding register and an RX valid pulse. Supports all four CPOL/CPHA modes, MSB first.

Parameters:
DATA_W, 8, word length in bits (2..16)
SYNC_STAGES, 2, synchroniser depth on SCLK/CS_n/MOSI (>=2)
IDLE_WORD, all-ones (8'hFF at default), word shifted out when no TX data is held at word start

Ports:
sys_clk_in  in  1  system clock; all logic on its rising edge
rst_n  in  1  asynchronous active-low reset
spi_cpol  in  1  clock polarity; sampled only while CS_n is inactive
spi_cpha  in  1  clock phase; sampled only while CS_n is inactive
spi_sclk_in  in  1  external SPI clock (async)
spi_cs_n_in  in  1  external chip select, active low (async)
spi_mosi_in  in  1  external serial data in (async)
spi_miso_out  out  1  serial data out
spi_miso_oe  out  1  MISO output enable, high while selected
tx_data  in  DATA_W  word to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  holding register empty
rx_data  out  DATA_W  last received word
rx_valid  out  1  one-cycle pulse, rx_data new
tx_underrun  out  1  one-cycle pulse, IDLE_WORD loaded
busy  out  1  transfer in progress (state XFER)

Behaviour:
- Reset values: spi_miso_out=0, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, busy=0. The synchronisers reset as follows: SCLK to 0, CS_n to 1, MOSI to 0. Mode latch, counters, shift registers and holding register all clear.
- Each async input passes through SYNC_STAGES flops. Edges are detected against a further registered copy. Detection latency is SYNC_STAGES+1 cycles.
- Usage constraint: each SCLK half-period is at least 4 sys_clk_in cycles (divide ratio >= 3). Faster SCLK is unsupported and is not checked.
- Mode latch: cpol/cpha are captured every cycle while synced CS_n=1 and frozen while selected.
- Edge naming:
  - Leading edge = synced SCLK going away from CPOL. Trailing edge = returning to CPOL.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other edge.
- TX holding register:
  - tx_ready = ~hold_full. A transfer occurs when tx_valid && tx_ready; hold_full is then set.
  - At each word load, hold_full clears in the same cycle. A new tx_valid&&tx_ready in that same cycle refills it; the load takes the old content.
- FSM, IDLE:
  - spi_miso_oe=0, busy=0.
  - Synced CS_n falling -> XFER. In the same cycle: bit_cnt=0, word load.
- FSM, XFER:
  - spi_miso_oe=1, busy=1.
  - Sample edge: rx_shift <= {rx_shift[DATA_W-2:0], mosi_sync} and bit_cnt+1.
  - When bit_cnt reaches DATA_W-1 on a sample edge:
    - rx_data <= completed word, rx_valid pulses next cycle.
    - bit_cnt wraps to 0.
    - CPHA=0: reload on that same sample edge's cycle so the next word's MSB is prepared by the following shift edge.
    - CPHA=1: reload at the next leading edge.
  - Shift edge: MISO advances to the next bit.
  - CPHA=0: the first shift edge of a word is not skipped. The word-load MSB is presented on CS fall, and shifting begins at the first trailing edge.
  - CPHA=1: the first leading edge presents the MSB.
- Word load: tx_shift <= hold_full ? hold : IDLE_WORD. If empty, tx_underrun pulses one cycle.
- spi_miso_out = tx_shift MSB while selected; 0 when spi_miso_oe=0.
- Synced CS_n rising in XFER -> IDLE:
  - A partial word (bit_cnt != 0) is discarded, with no rx_valid.
  - The holding register is untouched.
  - Mode latch reopens.
- Edges seen while CS_n=1 are ignored.
- Simultaneous CS_n rise and sample edge: the CS rise wins and the edge is ignored.
- rx_valid has no backpressure. Consecutive words overwrite rx_data. rx_valid is high for exactly one cycle per word.
- Async reset mid-transfer returns everything to reset values immediately. The next transfer needs a fresh CS_n fall.

Test Plan:
- Mode 0, DATA_W=8:
  - Stimulus: preload tx 8'hA5; master sends 8'h3C at sys/8.
  - Required: MISO bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid high for 1 cycle, SYNC_STAGES+1 cycles after the 8th rising SCLK; tx_ready back to 1 at CS fall.
- All four CPOL/CPHA combos:
  - Stimulus: loopback 8'h81 then 8'h7E in one CS window.
  - Required: two rx_valid pulses with 8'h81, 8'h7E; MISO matches the preloaded words in each mode.
- Underrun:
  - Stimulus: no tx_valid before CS fall.
  - Required: tx_underrun one pulse; MISO shifts 8'hFF.
  - Stimulus: tx_valid arrives mid-word.
  - Required: that word appears in word 2.
- Abort:
  - Stimulus: CS_n rises after 5 bits.
  - Required: no rx_valid; busy falls; next transfer's first rx_data is a full fresh word.
- Reset mid-word:
  - Stimulus: rst_n low at bit 3.
  - Required: all outputs at reset values within the same cycle; a subsequent transfer of 8'h55 is received correctly.
- Mode latch:
  - Stimulus: toggle spi_cpha during an active transfer.
  - Required: sampling is unaffected; the new mode applies only after CS_n goes high.

Source files
------------

// File: rtl/spi_slave_if.sv
// SPI target endpoint: oversamples SCLK/CS_n/MOSI in the sys_clk_in domain and
// moves DATA_W-bit words MSB first in all four CPOL/CPHA modes.
module spi_slave_if #(
    parameter int                DATA_W      = 8,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_WORD   = '1
) (
    input  logic              sys_clk_in,
    input  logic              rst_n,
    input  logic              spi_cpol,
    input  logic              spi_cpha,
    input  logic              spi_sclk_in,
    input  logic              spi_cs_n_in,
    input  logic              spi_mosi_in,
    output logic              spi_miso_out,
    output logic              spi_miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              busy
);

    localparam int               CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // state | meaning
    // IDLE  | deselected, MISO released, mode latch open
    // XFER  | selected, sampling/shifting on synced SCLK edges
    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_ff, cs_ff, mosi_ff;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_d, cs_d;
    logic                   cpol_q, cpha_q;

    logic                   sclk_chg, lead_edge, trail_edge;
    logic                   sample_edge, shift_edge;
    logic                   cs_fall, cs_rise;

    logic                   do_start, do_sample, do_shift;
    logic                   word_end, load_now, shift_now;
    logic                   need_load;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_shift;
    logic [DATA_W-1:0]      tx_shift;
    logic [DATA_W-1:0]      hold;
    logic                   hold_full;
    logic                   accept;

    always_ff @(posedge sys_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sclk_ff <= '0;
            cs_ff   <= '1;
            mosi_ff <= '0;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
        end else begin
            sclk_ff <= {sclk_ff[SYNC_STAGES-2:0], spi_sclk_in};
            cs_ff   <= {cs_ff[SYNC_STAGES-2:0], spi_cs_n_in};
            mosi_ff <= {mosi_ff[SYNC_STAGES-2:0], spi_mosi_in};
            sclk_d  <= sclk_ff[SYNC_STAGES-1];
            cs_d    <= cs_ff[SYNC_STAGES-1];
        end
    end

    assign sclk_s = sclk_ff[SYNC_STAGES-1];
    assign cs_s   = cs_ff[SYNC_STAGES-1];
    assign mosi_s = mosi_ff[SYNC_STAGES-1];

    // Mode follows the pins only while deselected, so a mid-word change is harmless.
    always_ff @(posedge sys_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
        end else if (cs_s) begin
            cpol_q <= spi_cpol;
            cpha_q <= spi_cpha;
        end
    end

    assign sclk_chg    = sclk_s ^ sclk_d;
    assign lead_edge   = sclk_chg & (sclk_s != cpol_q);
    assign trail_edge  = sclk_chg & (sclk_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;

    always_ff @(posedge sys_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        do_start    = 1'b0;
        do_sample   = 1'b0;
        do_shift    = 1'b0;
        spi_miso_oe = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = XFER;
                    do_start  = 1'b1;
                end
            end
            XFER: begin
                spi_miso_oe = 1'b1;
                busy        = 1'b1;
                if (cs_rise) begin
                    state_nxt = IDLE;
                end else begin
                    do_sample = sample_edge;
                    do_shift  = shift_edge;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A shift edge with bit_cnt==0 is either the word's first edge (MSB already
    // on MISO) or, in CPHA=1, the deferred reload point for the next word.
    assign word_end  = do_sample & (bit_cnt == LAST_BIT);
    assign load_now  = do_start | (word_end & ~cpha_q) | (do_shift & cpha_q & need_load);
    assign shift_now = do_shift & ~load_now & (bit_cnt != '0);

    assign accept   = tx_valid & tx_ready;
    assign tx_ready = ~hold_full;

    always_ff @(posedge sys_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            if (accept) begin
                hold <= tx_data;
            end
            if (accept) begin
                hold_full <= 1'b1;
            end else if (load_now) begin
                hold_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            tx_shift    <= '0;
            tx_underrun <= 1'b0;
            need_load   <= 1'b0;
        end else begin
            rx_valid    <= word_end;
            tx_underrun <= load_now & ~hold_full;

            if (do_start) begin
                bit_cnt <= '0;
            end else if (do_sample) begin
                rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
                bit_cnt  <= word_end ? '0 : bit_cnt + CNT_W'(1);
            end

            if (word_end) begin
                rx_data <= {rx_shift[DATA_W-2:0], mosi_s};
            end

            if (load_now) begin
                tx_shift <= hold_full ? hold : IDLE_WORD;
            end else if (shift_now) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (state == IDLE || do_start || load_now) begin
                need_load <= 1'b0;
            end else if (word_end && cpha_q) begin
                need_load <= 1'b1;
            end
        end
    end

    assign spi_miso_out = spi_miso_oe & tx_shift[DATA_W-1];

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: drives an SPI master model and scores RX words and
// MISO words against a word-level model of the TX holding register.
`timescale 1ns/1ps
module tb_spi_slave_if;

    localparam int         DATA_W      = 8;
    localparam int         SYNC_STAGES = 2;
    localparam logic [7:0] IDLE_WORD   = 8'hFF;

    logic       sys_clk_in  = 1'b0;
    logic       rst_n       = 1'b0;
    logic       spi_cpol    = 1'b0;
    logic       spi_cpha    = 1'b0;
    logic       spi_sclk_in = 1'b0;
    logic       spi_cs_n_in = 1'b1;
    logic       spi_mosi_in = 1'b0;
    logic       spi_miso_out;
    logic       spi_miso_oe;
    logic [7:0] tx_data     = 8'h00;
    logic       tx_valid    = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    spi_slave_if #(
        .DATA_W     (DATA_W),
        .SYNC_STAGES(SYNC_STAGES),
        .IDLE_WORD  (IDLE_WORD)
    ) dut (
        .sys_clk_in  (sys_clk_in),
        .rst_n       (rst_n),
        .spi_cpol    (spi_cpol),
        .spi_cpha    (spi_cpha),
        .spi_sclk_in (spi_sclk_in),
        .spi_cs_n_in (spi_cs_n_in),
        .spi_mosi_in (spi_mosi_in),
        .spi_miso_out(spi_miso_out),
        .spi_miso_oe (spi_miso_oe),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    always #5 sys_clk_in = ~sys_clk_in;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_sample_cyc = 0;
    int ur_seen     = 0;
    int exp_ur      = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] mosi_q[$];

    // word-level model of the TX holding register
    logic       m_hold_full = 1'b0;
    logic [7:0] m_hold      = 8'h00;
    logic [7:0] exp_cur     = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge sys_clk_in);
    endtask

    initial forever begin
        @(posedge sys_clk_in);
        cyc++;
    end

    // monitor: pops expected words whenever the DUT flags a new RX word
    initial forever begin
        logic [7:0] e;
        @(negedge sys_clk_in);
        if (tx_underrun === 1'b1) ur_seen++;
        if (rx_valid === 1'b1) begin
            if (rx_exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL rx_spurious: got rx_valid with rx_data %0h, expected no word", rx_data);
            end else begin
                e = rx_exp_q.pop_front();
                check("rx_data", rx_data, e);
                check("rx_latency", cyc - last_sample_cyc, SYNC_STAGES + 1);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic model_load();
        exp_cur = m_hold_full ? m_hold : IDLE_WORD;
        if (!m_hold_full) exp_ur++;
        m_hold_full = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        int k;
        check("tx_ready_before_push", tx_ready, !m_hold_full);
        tx_data  = d;
        tx_valid = 1'b1;
        for (k = 0; k < 40; k++) begin
            if (tx_ready === 1'b1) break;
            @(negedge sys_clk_in);
        end
        if (k == 40) begin
            vectors++;
            miscompares++;
            $display("FAIL tx_handshake: got tx_ready 0 for 40 cycles, expected 1");
        end
        @(posedge sys_clk_in);
        @(negedge sys_clk_in);
        tx_valid    = 1'b0;
        m_hold      = d;
        m_hold_full = 1'b1;
    endtask

    task automatic check_reset_values();
        check("rst_miso", spi_miso_out, 0);
        check("rst_oe", spi_miso_oe, 0);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_underrun", tx_underrun, 0);
        check("rst_busy", busy, 0);
    endtask

    // one CS window of nbits bits; negative bit indices disable the option
    task automatic run_xfer(input bit cpol, input bit cpha, input int nbits, input int half,
                            input int push_bit, input logic [7:0] push_word,
                            input int rst_bit, input int flip_bit);
        logic [7:0] cur;
        logic [7:0] got;
        int         wb;
        cur = 8'h00;
        got = 8'h00;
        spi_cpol    = cpol;
        spi_cpha    = cpha;
        spi_sclk_in = cpol;
        spi_cs_n_in = 1'b1;
        wait_neg(8);
        check("tx_ready_pre", tx_ready, !m_hold_full);
        spi_cs_n_in = 1'b0;
        model_load();
        wait_neg(half + 2);
        check("tx_ready_cs_fall", tx_ready, !m_hold_full);
        check("busy_active", busy, 1);
        check("oe_active", spi_miso_oe, 1);
        for (int b = 0; b < nbits; b++) begin
            wb = b % 8;
            if (b == rst_bit) begin
                rst_n = 1'b0;
                #1;
                check_reset_values();
                spi_cs_n_in = 1'b1;
                spi_sclk_in = cpol;
                m_hold_full = 1'b0;
                wait_neg(3);
                rst_n = 1'b1;
                wait_neg(8);
                return;
            end
            if (b == push_bit) push_tx(push_word);
            if (b == flip_bit) spi_cpha = ~spi_cpha;
            if (wb == 0) begin
                if (mosi_q.size() != 0) cur = mosi_q.pop_front();
                else cur = 8'($urandom);
                got = 8'h00;
                if (b > 0 && cpha) model_load();
            end
            if (!cpha) begin
                spi_mosi_in = cur[7-wb];
                got = {got[6:0], spi_miso_out};
                if (wb == 7) begin
                    rx_exp_q.push_back(cur);
                    last_sample_cyc = cyc;
                end
                spi_sclk_in = ~cpol;
                wait_neg(half);
                spi_sclk_in = cpol;
                wait_neg(half);
            end else begin
                spi_sclk_in = ~cpol;
                spi_mosi_in = cur[7-wb];
                wait_neg(half);
                got = {got[6:0], spi_miso_out};
                if (wb == 7) begin
                    rx_exp_q.push_back(cur);
                    last_sample_cyc = cyc;
                end
                spi_sclk_in = cpol;
                wait_neg(half);
            end
            if (wb == 7) begin
                check("miso_word", got, exp_cur);
                if (!cpha) model_load();
            end
        end
        spi_cs_n_in = 1'b1;
        spi_sclk_in = cpol;
        wait_neg(half + 6);
        check("busy_after_cs", busy, 0);
        check("oe_after_cs", spi_miso_oe, 0);
        check("miso_after_cs", spi_miso_out, 0);
        check("underrun_count", ur_seen, exp_ur);
    endtask

    initial begin
        wait_neg(5);
        check_reset_values();
        rst_n = 1'b1;
        wait_neg(4);

        // mode 0 basic word
        push_tx(8'hA5);
        mosi_q = '{8'h3C};
        run_xfer(1'b0, 1'b0, 8, 4, -1, 8'h00, -1, -1);

        // loopback two words in every mode
        for (int m = 0; m < 4; m++) begin
            push_tx(8'h81);
            mosi_q = '{8'h81, 8'h7E};
            run_xfer(m[1], m[0], 16, 4, 3, 8'h7E, -1, -1);
        end

        // underrun on word 1, data arriving mid-word shows up in word 2
        mosi_q = '{8'h12, 8'h34};
        run_xfer(1'b0, 1'b1, 16, 5, 3, 8'hC3, -1, -1);

        // abort after 5 bits, then a fresh full word
        push_tx(8'h96);
        mosi_q = '{8'h5A};
        run_xfer(1'b1, 1'b0, 5, 4, -1, 8'h00, -1, -1);
        mosi_q = '{8'hE7};
        run_xfer(1'b1, 1'b0, 8, 4, -1, 8'h00, -1, -1);

        // reset at bit 3, then receive 8'h55
        mosi_q = '{8'hAA};
        run_xfer(1'b0, 1'b0, 8, 4, 1, 8'h33, 3, -1);
        mosi_q = '{8'h55};
        run_xfer(1'b0, 1'b0, 8, 4, -1, 8'h00, -1, -1);

        // cpha toggled while selected, then used after deselect
        push_tx(8'h6B);
        mosi_q = '{8'hC6, 8'h39};
        run_xfer(1'b0, 1'b0, 16, 4, 10, 8'hD2, -1, 5);
        push_tx(8'h4E);
        mosi_q = '{8'h9D};
        run_xfer(1'b0, 1'b1, 8, 4, -1, 8'h00, -1, -1);

        // randomized transfers
        for (int r = 0; r < 12; r++) begin
            int nwords;
            int half;
            int pbit;
            nwords = $urandom_range(1, 3);
            half   = $urandom_range(4, 7);
            pbit   = ($urandom % 2 == 1) ? $urandom_range(1, 6) : -1;
            if (!m_hold_full && ($urandom % 2 == 1)) push_tx(8'($urandom));
            mosi_q = {};
            for (int w = 0; w < nwords; w++) mosi_q.push_back(8'($urandom));
            run_xfer(1'($urandom), 1'($urandom), nwords * 8, half, pbit, 8'($urandom), -1, -1);
        end

        wait_neg(10);
        check("rx_pending", rx_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
